// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receiver control path.
package uart_rx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PS_WIDTH_DEF   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
  } rx_state_e;
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter for the UART receive FSM.
module uart_rx_edge_bit_cnt #(
  parameter int DATA_WIDTH = 8,
  parameter int PS_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cnt_en,
  input  logic                bit_inc,
  input  logic                bit_clr,
  input  logic [PS_WIDTH-1:0] ps_q,
  output logic [PS_WIDTH-1:0] edge_cnt,
  output logic [3:0]          bit_cnt,
  output logic                last_edge
);
  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  assign last_edge = cnt_en && (edge_cnt == ps_q - PS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || !cnt_en || last_edge) edge_cnt <= '0;
    else                             edge_cnt <= edge_cnt + PS_WIDTH'(1);
  end

  // Wrap after the final data bit so bit_cnt reads 0 once the data phase is over.
  always_ff @(posedge clk) begin
    if (rst || bit_clr) bit_cnt <= '0;
    else if (bit_inc)   bit_cnt <= (bit_cnt == BIT_LAST) ? 4'd0 : bit_cnt + 4'd1;
  end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive sequencing FSM: frames start/data/parity/stop bits and strobes the checkers.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PS_WIDTH   = PS_WIDTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic                PAR_EN,
  input  logic [PS_WIDTH-1:0] Prescale,
  input  logic                strt_glitch,
  input  logic                par_err,
  input  logic                stp_err,
  output logic                dat_samp_en,
  output logic [PS_WIDTH-1:0] edge_cnt,
  output logic [3:0]          bit_cnt,
  output logic                strt_chk_en,
  output logic                deser_en,
  output logic                par_chk_en,
  output logic                stp_chk_en,
  output logic                data_valid,
  output logic                busy
);
  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  rx_state_e           state, state_nxt;
  logic [PS_WIDTH-1:0] ps_q;
  logic                par_q, perr_q;
  logic                cnt_en, bit_inc, bit_clr, last_edge;
  logic                frame_start;

  assign frame_start = (state == IDLE) && !RX_IN;

  uart_rx_edge_bit_cnt #(.DATA_WIDTH(DATA_WIDTH), .PS_WIDTH(PS_WIDTH)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .cnt_en   (cnt_en),
    .bit_inc  (bit_inc),
    .bit_clr  (bit_clr),
    .ps_q     (ps_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .last_edge(last_edge)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      ps_q   <= '0;
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        ps_q  <= Prescale;
        par_q <= PAR_EN;
      end
      // Also cleared at frame start so a parity failure cannot leak into a later no-parity frame.
      if (par_chk_en)                         perr_q <= par_err;
      else if (state == VALID || frame_start) perr_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    busy        = (state != IDLE);
    cnt_en      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    dat_samp_en = cnt_en;
    case (state)
      IDLE: if (!RX_IN) state_nxt = START;
      START: if (last_edge) begin
        strt_chk_en = 1'b1;
        if (strt_glitch) state_nxt = IDLE;
        else begin
          state_nxt = DATA;
          bit_clr   = 1'b1;
        end
      end
      DATA: if (last_edge) begin
        deser_en = 1'b1;
        bit_inc  = 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = par_q ? PARITY : STOP;
      end
      PARITY: if (last_edge) begin
        par_chk_en = 1'b1;
        state_nxt  = STOP;
      end
      STOP: if (last_edge) begin
        stp_chk_en = 1'b1;
        state_nxt  = (stp_err || perr_q) ? IDLE : VALID;
      end
      VALID: begin
        data_valid = 1'b1;
        state_nxt  = RX_IN ? IDLE : START;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; data_valid timing is scoreboarded against expected cycles.
module tb_uart_rx_frame_ctrl;
  localparam int DW  = 8;
  localparam int PSW = 6;

  logic           CLK = 1'b0;
  logic           RST, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
  logic [PSW-1:0] Prescale;
  logic           dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy;
  logic [PSW-1:0] edge_cnt;
  logic [3:0]     bit_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_deser = 0;
  int n_par   = 0;
  int q_dv[$];

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PS_WIDTH(PSW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every data_valid pulse must match the next expected cycle.
  always @(negedge CLK) begin
    if (deser_en)   n_deser = n_deser + 1;
    if (par_chk_en) n_par   = n_par + 1;
    if (data_valid) begin
      total = total + 1;
      assert (q_dv.size() > 0) else begin
        bad = bad + 1;
        $error("FAIL dv_unexpected: data_valid at cycle %0d, expected none", cyc);
      end
      if (q_dv.size() > 0) begin
        int exp_c;
        exp_c = q_dv.pop_front();
        total = total + 1;
        assert (cyc === exp_c) else begin
          bad = bad + 1;
          $error("FAIL dv_cycle: got cycle %0d expected %0d", cyc, exp_c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic logic [31:0] out_flags();
    return 32'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy,
                edge_cnt, bit_cnt});
  endfunction

  // Drives one frame; returns in the STOP last-edge cycle. ps_mid != ps also flips PAR_EN mid-frame.
  task automatic send_frame(input int ps, input int ps_mid, input logic [7:0] d, input bit pe,
                            input bit pbad, input bit sbad, input bit good);
    int c0;
    Prescale = PSW'(ps); PAR_EN = pe; par_err = pbad; stp_err = sbad; strt_glitch = 1'b0;
    RX_IN = 1'b0;
    c0 = cyc;
    if (good) q_dv.push_back(c0 + 1 + (10 + int'(pe)) * ps);
    step();
    chk("start_edge0", 32'(edge_cnt), 32'(0));
    chk("start_busy", 32'({busy, dat_samp_en}), 32'(3));
    steps(ps - 1);
    Prescale = PSW'(ps_mid);
    if (ps_mid != ps) PAR_EN = ~pe;
    for (int i = 0; i < DW; i++) begin
      RX_IN = d[i];
      steps(ps);
    end
    if (pe) begin
      RX_IN = ^d;
      steps(ps);
    end
    RX_IN = 1'b1;
    Prescale = PSW'(ps);
    PAR_EN = pe;
    steps(ps);
    chk("stp_strobe", 32'(stp_chk_en), 32'(1));
  endtask

  initial begin
    int d0, p0, t1;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    steps(3);
    chk("reset_outs", out_flags(), 32'(0));
    RST = 1'b0;
    steps(2);
    chk("idle_outs", out_flags(), 32'(0));

    // T1: Prescale 8, no parity
    d0 = n_deser; p0 = n_par;
    send_frame(8, 8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("t1_dv", 32'(data_valid), 32'(1));
    chk("t1_deser", 32'(n_deser - d0), 32'(8));
    chk("t1_par", 32'(n_par - p0), 32'(0));
    step();
    chk("t1_idle", out_flags(), 32'(0));

    // T2: parity good, then parity error
    p0 = n_par;
    send_frame(8, 8, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t2_dv", 32'(data_valid), 32'(1));
    chk("t2_par", 32'(n_par - p0), 32'(1));
    step();
    send_frame(8, 8, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("t2_perr_idle", 32'({busy, data_valid}), 32'(0));

    // T3: 3-cycle glitch, Prescale 16
    d0 = n_deser;
    Prescale = 6'd16; PAR_EN = 1'b0; strt_glitch = 1'b1; RX_IN = 1'b0;
    step();
    chk("t3_busy", 32'(busy), 32'(1));
    steps(2);
    RX_IN = 1'b1;
    steps(13);
    chk("t3_strt_strobe", 32'(strt_chk_en), 32'(1));
    step();
    chk("t3_idle", out_flags(), 32'(0));
    chk("t3_deser", 32'(n_deser - d0), 32'(0));
    strt_glitch = 1'b0;
    steps(2);

    // T4: stop error
    send_frame(8, 8, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("t4_idle", out_flags(), 32'(0));
    stp_err = 1'b0;
    steps(2);

    // T5: back-to-back at Prescale 32, Prescale/PAR_EN disturbed mid-frame
    send_frame(32, 8, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t5_dv1", 32'(data_valid), 32'(1));
    t1 = cyc;
    send_frame(32, 8, 8'h69, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t5_dv2", 32'(data_valid), 32'(1));
    chk("t5_gap", 32'(cyc - t1), 32'(353));
    step();
    chk("t5_idle", 32'(busy), 32'(0));

    // T6: reset in DATA with bit_cnt=4, then a clean frame
    d0 = n_deser;
    Prescale = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0;
    steps(43);
    chk("t6_bitcnt", 32'(bit_cnt), 32'(4));
    chk("t6_deser", 32'(n_deser - d0), 32'(4));
    RST = 1'b1; RX_IN = 1'b1;
    step();
    chk("t6_reset_outs", out_flags(), 32'(0));
    RST = 1'b0;
    steps(2);
    send_frame(8, 8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("t6_dv", 32'(data_valid), 32'(1));
    step();

    for (int i = 0; i < 20 && q_dv.size() > 0; i++) step();
    chk("sb_empty", 32'(q_dv.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
